// File: rtl/irda_mode_switch.sv
// ---------------------------------------------------------------------------
// irda_mode_switch
//
// Takes the decoded mode bits from the IrDA master register and applies them
// to the PHY without breaking a frame. It holds the "active" configuration
// (mode, direction, loopback). A register change waits until both the TX and
// RX paths are idle, or until a timeout runs out. The new configuration is
// then loaded and a PHY reset is held for a settle window. The block also
// produces the bit/chip-rate enable for the active speed.
//
// Ports
//   clk             system clock
//   wb_rst_i        synchronous active-high reset
//   fast_mode       master reg: MIR or FIR selected (informational only)
//   mir_mode        master reg: MIR selected
//   mir_half        master reg: half-speed MIR
//   fir_mode        master reg: FIR selected
//   tx_select       master reg: 1 = transmit, 0 = receive
//   loopback_enable master reg: loopback request
//   sir_divisor     clk cycles per SIR bit (0 is treated as 1)
//   tx_busy         transmitter mid-frame
//   rx_busy         receiver mid-frame
//   active_mode     00 SIR, 01 FIR, 10 MIR half, 11 MIR full
//   active_tx       applied tx_select
//   active_lb       applied loopback
//   phy_rst         PHY pipe reset, high during settle
//   bit_tick        one-cycle rate enable
//   switch_pending  change requested, waiting for idle
//   switch_forced   one-cycle pulse when a switch was forced by timeout
//
// Busy semantics: tx_busy/rx_busy are plain levels, not a valid/ready pair.
// The switch may happen in any cycle where both are low. No acknowledge is
// returned, because the PHY reset that follows the switch is the only
// notification the pipes get.
// ---------------------------------------------------------------------------
module irda_mode_switch #(
    parameter int MIR_DIV       = 42,
    parameter int FIR_DIV       = 6,
    parameter int SETTLE_CYCLES = 16,
    parameter int WAIT_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        fast_mode,
    input  logic        mir_mode,
    input  logic        mir_half,
    input  logic        fir_mode,
    input  logic        tx_select,
    input  logic        loopback_enable,
    input  logic [15:0] sir_divisor,
    input  logic        tx_busy,
    input  logic        rx_busy,
    output logic [1:0]  active_mode,
    output logic        active_tx,
    output logic        active_lb,
    output logic        phy_rst,
    output logic        bit_tick,
    output logic        switch_pending,
    output logic        switch_forced
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_SETTLE    = 2'd2
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST   = 16'(WAIT_TIMEOUT - 1);
    localparam logic        TIMEOUT_EN  = (WAIT_TIMEOUT != 0);
    localparam logic [15:0] D_FIR       = 16'(FIR_DIV);
    localparam logic [15:0] D_MIR_FULL  = 16'(MIR_DIV);
    localparam logic [15:0] D_MIR_HALF  = 16'(2 * MIR_DIV);

    // The state register is kept as a named enum so checkers can bind to it.
    state_t      state;
    state_t      state_nxt;
    logic [1:0]  req_mode;
    logic        req_differs;
    logic        paths_idle;
    logic        timeout_hit;
    logic [15:0] settle_cnt;
    logic [15:0] wait_cnt;
    logic [15:0] div_cnt;
    logic [15:0] tick_div;
    logic        counting;

    // fast_mode does not take part in the decode.
    logic unused_fast;
    assign unused_fast = fast_mode;

    always_comb begin
        req_mode = 2'b00;
        if (fir_mode)
            req_mode = 2'b01;
        else if (mir_mode && mir_half)
            req_mode = 2'b10;
        else if (mir_mode)
            req_mode = 2'b11;
    end

    assign req_differs = {req_mode, tx_select, loopback_enable} !=
                         {active_mode, active_tx, active_lb};
    assign paths_idle  = !tx_busy && !rx_busy;
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

    // The divider follows the active mode, so an in-flight frame keeps its rate
    // while a switch is pending.
    always_comb begin
        tick_div = 16'd1;
        case (active_mode)
            2'b00:   tick_div = (sir_divisor == 16'd0) ? 16'd1 : sir_divisor;
            2'b01:   tick_div = D_FIR;
            2'b10:   tick_div = D_MIR_HALF;
            default: tick_div = D_MIR_FULL;
        endcase
    end

    // A reverted request has priority, so no needless PHY reset happens.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:
                if (req_differs) state_nxt = ST_WAIT_IDLE;
            ST_WAIT_IDLE:
                if (!req_differs)                 state_nxt = ST_RUN;
                else if (paths_idle || timeout_hit) state_nxt = ST_SETTLE;
            ST_SETTLE:
                if (settle_cnt == SETTLE_LAST) state_nxt = ST_RUN;
            default:
                state_nxt = ST_SETTLE;
        endcase
    end

    // The divider runs in RUN and WAIT_IDLE. It is held at zero across SETTLE,
    // and on the edge into it, so the first tick comes D cycles into RUN.
    assign counting = (state != ST_SETTLE) && (state_nxt != ST_SETTLE);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state          <= ST_SETTLE;
            settle_cnt     <= 16'd0;
            wait_cnt       <= 16'd0;
            div_cnt        <= 16'd0;
            active_mode    <= 2'b00;
            active_tx      <= 1'b0;
            active_lb      <= 1'b0;
            phy_rst        <= 1'b1;
            bit_tick       <= 1'b0;
            switch_pending <= 1'b0;
            switch_forced  <= 1'b0;
        end else begin
            state          <= state_nxt;
            phy_rst        <= (state_nxt == ST_SETTLE);
            switch_pending <= (state_nxt == ST_WAIT_IDLE);
            switch_forced  <= (state == ST_WAIT_IDLE) && req_differs &&
                              !paths_idle && timeout_hit;

            settle_cnt <= (state == ST_SETTLE && state_nxt == ST_SETTLE) ?
                          settle_cnt + 16'd1 : 16'd0;
            wait_cnt   <= (state == ST_WAIT_IDLE && state_nxt == ST_WAIT_IDLE) ?
                          wait_cnt + 16'd1 : 16'd0;

            // The active tuple only changes on the edge from WAIT_IDLE into SETTLE.
            if (state == ST_WAIT_IDLE && state_nxt == ST_SETTLE) begin
                active_mode <= req_mode;
                active_tx   <= tx_select;
                active_lb   <= loopback_enable;
            end

            // Using >= means a divider that shrinks below the count wraps at once.
            if (counting) begin
                if (div_cnt >= tick_div - 16'd1) begin
                    div_cnt  <= 16'd0;
                    bit_tick <= 1'b1;
                end else begin
                    div_cnt  <= div_cnt + 16'd1;
                    bit_tick <= 1'b0;
                end
            end else begin
                div_cnt  <= 16'd0;
                bit_tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irda_mode_switch.sv
module tb_irda_mode_switch;

    localparam int MIR_DIV = 42;
    localparam int FIR_DIV = 6;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        fast_mode = 1'b0;
    logic        mir_mode = 1'b0;
    logic        mir_half = 1'b0;
    logic        fir_mode = 1'b0;
    logic        tx_select = 1'b0;
    logic        loopback_enable = 1'b0;
    logic [15:0] sir_divisor = 16'd4;
    logic        tx_busy = 1'b0;
    logic        rx_busy = 1'b0;
    logic [1:0]  active_mode;
    logic        active_tx;
    logic        active_lb;
    logic        phy_rst;
    logic        bit_tick;
    logic        switch_pending;
    logic        switch_forced;

    always #5 clk = ~clk;

    irda_mode_switch #(
        .MIR_DIV(MIR_DIV), .FIR_DIV(FIR_DIV),
        .SETTLE_CYCLES(SETTLE), .WAIT_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .fast_mode(fast_mode),
        .mir_mode(mir_mode), .mir_half(mir_half), .fir_mode(fir_mode),
        .tx_select(tx_select), .loopback_enable(loopback_enable),
        .sir_divisor(sir_divisor), .tx_busy(tx_busy), .rx_busy(rx_busy),
        .active_mode(active_mode), .active_tx(active_tx), .active_lb(active_lb),
        .phy_rst(phy_rst), .bit_tick(bit_tick),
        .switch_pending(switch_pending), .switch_forced(switch_forced)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks settle cycles left, whether a switch is waiting and how
    // long it has waited, and cycles elapsed since the last tick.
    function automatic int req_of(input logic fir, input logic mir, input logic half);
        if (fir) return 1;
        if (mir && half) return 2;
        if (mir) return 3;
        return 0;
    endfunction

    function automatic int div_of(input int mode, input int sdiv);
        case (mode)
            0:       return (sdiv < 1) ? 1 : sdiv;
            1:       return FIR_DIV;
            2:       return 2 * MIR_DIV;
            default: return MIR_DIV;
        endcase
    endfunction

    bit m_valid = 0;
    int m_mode, m_tx, m_lb, m_settle_left, m_waiting, m_wait_len, m_phase;
    int e_tick, e_forced;
    // {mode[1:0], tx, lb, phy, tick, pending, forced}
    logic [7:0] exp_q[$];

    task automatic model_step();
        int req;
        bit differs;
        bit go;
        int d;
        if (wb_rst_i) begin
            m_valid = 1;
            m_mode = 0; m_tx = 0; m_lb = 0;
            m_settle_left = SETTLE; m_waiting = 0; m_wait_len = 0; m_phase = 0;
            e_tick = 0; e_forced = 0;
            return;
        end
        if (!m_valid) return;
        req = req_of(fir_mode, mir_mode, mir_half);
        differs = (req != m_mode) || (int'(tx_select) != m_tx) ||
                  (int'(loopback_enable) != m_lb);
        e_tick = 0;
        e_forced = 0;
        if (m_settle_left > 0) begin
            m_settle_left--;
            m_phase = 0;
            return;
        end
        go = 0;
        if (m_waiting != 0) begin
            if (!differs) m_waiting = 0;
            else if (!tx_busy && !rx_busy) go = 1;
            else if (TIMEOUT != 0 && m_wait_len == TIMEOUT - 1) begin
                go = 1;
                e_forced = 1;
            end else m_wait_len++;
        end else if (differs) begin
            m_waiting = 1;
            m_wait_len = 0;
        end
        if (go) begin
            m_mode = req; m_tx = int'(tx_select); m_lb = int'(loopback_enable);
            m_waiting = 0; m_settle_left = SETTLE; m_phase = 0;
        end else begin
            d = div_of(m_mode, int'(sir_divisor));
            m_phase++;
            if (m_phase >= d) begin
                e_tick = 1;
                m_phase = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        if (m_valid)
            exp_q.push_back({2'(m_mode), 1'(m_tx), 1'(m_lb), (m_settle_left > 0),
                             1'(e_tick), 1'(m_waiting), 1'(e_forced)});
    end

    // ---------------- scoreboard ----------------
    initial forever begin
        logic [7:0] e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_mode",    int'(active_mode),    int'(e[7:6]));
            check("sb_tx",      int'(active_tx),      int'(e[5]));
            check("sb_lb",      int'(active_lb),      int'(e[4]));
            check("sb_phy_rst", int'(phy_rst),        int'(e[3]));
            check("sb_tick",    int'(bit_tick),       int'(e[2]));
            check("sb_pending", int'(switch_pending), int'(e[1]));
            check("sb_forced",  int'(switch_forced),  int'(e[0]));
        end
    end

    // ---------------- directed + random driver ----------------
    initial begin
        // 1: reset, SIR divisor 4
        step(3);
        check("rst_phy", int'(phy_rst), 1);
        check("rst_mode", int'(active_mode), 0);
        check("rst_pending", int'(switch_pending), 0);
        wb_rst_i = 1'b0;
        step(15);
        check("settle_phy_hi", int'(phy_rst), 1);
        step(1);
        check("run_phy_lo", int'(phy_rst), 0);
        check("run_first_tick0", int'(bit_tick), 0);
        step(3);
        check("sir_tick_early", int'(bit_tick), 0);
        step(1);
        check("sir_first_tick", int'(bit_tick), 1);
        step(1);
        check("sir_tick_after", int'(bit_tick), 0);

        // 2: idle switch to FIR
        fir_mode = 1'b1; fast_mode = 1'b1;
        step(1);
        check("fir_pending", int'(switch_pending), 1);
        step(1);
        check("fir_pending_fall", int'(switch_pending), 0);
        check("fir_mode", int'(active_mode), 1);
        check("fir_phy", int'(phy_rst), 1);
        step(16);
        check("fir_phy_lo", int'(phy_rst), 0);
        step(5);
        check("fir_tick_early", int'(bit_tick), 0);
        step(1);
        check("fir_tick", int'(bit_tick), 1);

        // 3: busy TX defers switch to MIR half
        fir_mode = 1'b0; mir_mode = 1'b1; mir_half = 1'b1; tx_busy = 1'b1;
        step(7);
        check("mirh_pending", int'(switch_pending), 1);
        check("mirh_old_mode", int'(active_mode), 1);
        tx_busy = 1'b0;
        step(1);
        check("mirh_mode", int'(active_mode), 2);
        check("mirh_not_forced", int'(switch_forced), 0);
        step(16);
        step(83);
        check("mirh_tick_early", int'(bit_tick), 0);
        step(1);
        check("mirh_tick", int'(bit_tick), 1);

        // 4: forced switch to MIR full by timeout
        rx_busy = 1'b1; mir_half = 1'b0;
        step(8);
        check("force_pending", int'(switch_pending), 1);
        check("force_early", int'(switch_forced), 0);
        step(1);
        check("force_pulse", int'(switch_forced), 1);
        check("force_mode", int'(active_mode), 3);
        step(1);
        check("force_pulse_end", int'(switch_forced), 0);
        rx_busy = 1'b0;
        step(20);

        // 5: revert while waiting
        tx_busy = 1'b1; tx_select = 1'b1;
        step(2);
        check("revert_pending", int'(switch_pending), 1);
        tx_select = 1'b0;
        step(1);
        check("revert_pending_fall", int'(switch_pending), 0);
        check("revert_phy", int'(phy_rst), 0);
        check("revert_mode", int'(active_mode), 3);
        step(10);
        tx_busy = 1'b0;

        // 6: reset mid-SETTLE and mid-RUN, SIR divisor 0
        mir_mode = 1'b0; fast_mode = 1'b0; tx_select = 1'b1;
        step(5);
        wb_rst_i = 1'b1; tx_select = 1'b0; sir_divisor = 16'd0;
        step(1);
        check("rst_settle_mode", int'(active_mode), 0);
        check("rst_settle_tx", int'(active_tx), 0);
        check("rst_settle_phy", int'(phy_rst), 1);
        wb_rst_i = 1'b0;
        step(16);
        step(1);
        check("div0_tick_a", int'(bit_tick), 1);
        step(1);
        check("div0_tick_b", int'(bit_tick), 1);
        wb_rst_i = 1'b1;
        step(1);
        check("rst_run_phy", int'(phy_rst), 1);
        check("rst_run_tick", int'(bit_tick), 0);
        wb_rst_i = 1'b0;

        // random soak, checked by the scoreboard
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                fir_mode  = ($urandom_range(0, 3) == 0);
                mir_mode  = 1'($urandom_range(0, 1));
                mir_half  = 1'($urandom_range(0, 1));
                fast_mode = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 39) == 0) tx_select = ~tx_select;
            if ($urandom_range(0, 39) == 0) loopback_enable = ~loopback_enable;
            if ($urandom_range(0, 5) == 0) tx_busy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) rx_busy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0)
                sir_divisor = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40))
                                                           : 16'($urandom_range(0, 5));
            wb_rst_i = ($urandom_range(0, 499) == 0);
            step(1);
        end
        wb_rst_i = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
